// File: rtl/vga_scene_pkg.sv
// Shared types and sizing helpers for the VGA scene sequencer.
package vga_scene_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } scene_t;

  localparam int FPS_DEF          = 60;
  localparam int OVER_TIMEOUT_DEF = 600;
  localparam int LONG_PRESS_DEF   = 120;

  localparam int FRAME_CNT_W = 16;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int STEP_W_DEF = $clog2(FPS_DEF);
  localparam int TMO_W_DEF  = $clog2(OVER_TIMEOUT_DEF);
  localparam int HOLD_W_DEF = $clog2(LONG_PRESS_DEF + 1);

endpackage

// File: rtl/vga_scene_ctrl_key_event.sv
// Key press edge detect, single-entry pending latch and long-press hold counter.
module scene_key_event
  import vga_scene_pkg::*;
#(
  parameter int LONG_PRESS = LONG_PRESS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_frame_start,
  input  logic i_hold_en,
  output logic o_pending,
  output logic o_long_hold
);

  localparam int HOLD_W = cnt_w(LONG_PRESS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);

  logic              key_prev_q, key_prev_d;
  logic              pending_q, pending_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press;
  logic              long_hold;

  assign press = key_prev_q & ~i_key;

  // Long hold fires on the frame start where the counter would reach LONG_PRESS.
  assign long_hold = i_hold_en & ~i_key & (hold_q >= HOLD_LAST);

  // Next-state: pending is rebuilt at every frame start from a same-cycle press only,
  // so such a press lands at the following frame start.
  always_comb begin
    key_prev_d = i_key;
    pending_d  = pending_q | press;
    hold_d     = hold_q;
    if (i_frame_start) begin
      pending_d = press & ~long_hold;
    end
    if (i_key || !i_hold_en) begin
      hold_d = '0;
    end else if (i_frame_start && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_prev_q <= 1'b1;
      pending_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
    end
  end

  assign o_pending   = pending_q;
  assign o_long_hold = long_hold;

endmodule

// File: rtl/vga_scene_ctrl.sv
// Frame-aligned scene sequencer: title, countdown, play, pause, game over.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  TITLE     | idle, waiting for a press to start a game
//  COUNTDOWN | 3..1 digit, FPS frame starts per digit, presses ignored
//  PLAY      | game running, frame counter advancing
//  PAUSE     | game frozen, press resumes, long press aborts
//  OVER      | game over screen, press or timeout returns to TITLE
module vga_scene_ctrl
  import vga_scene_pkg::*;
#(
  parameter int FPS          = FPS_DEF,
  parameter int OVER_TIMEOUT = OVER_TIMEOUT_DEF,
  parameter int LONG_PRESS   = LONG_PRESS_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key,
  input  logic        i_frame_start,
  input  logic        i_game_over,
  output logic [2:0]  o_scene,
  output logic [1:0]  o_countdown,
  output logic [15:0] o_frame_cnt,
  output logic        o_scene_changed,
  output logic        o_game_rst
);

  localparam int STEP_W = cnt_w(FPS - 1);
  localparam int TMO_W  = cnt_w(OVER_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FPS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(OVER_TIMEOUT - 1);

  scene_t                 scene_q, scene_d;
  logic [1:0]             countdown_q, countdown_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   scene_changed_q, scene_changed_d;
  logic                   game_rst_q, game_rst_d;

  logic pending;
  logic long_hold;
  logic hold_en;

  assign hold_en = (scene_q == PLAY) || (scene_q == PAUSE);

  scene_key_event #(
    .LONG_PRESS (LONG_PRESS)
  ) u_key_event (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_key         (i_key),
    .i_frame_start (i_frame_start),
    .i_hold_en     (hold_en),
    .o_pending     (pending),
    .o_long_hold   (long_hold)
  );

  // Scene transitions and counters; nothing moves outside a frame start.
  always_comb begin
    scene_d      = scene_q;
    countdown_d  = countdown_q;
    step_d       = step_q;
    frame_cnt_d  = frame_cnt_q;
    tmo_d        = tmo_q;
    game_rst_d   = 1'b0;
    if (i_frame_start) begin
      case (scene_q)
        TITLE: begin
          if (pending) begin
            scene_d     = COUNTDOWN;
            countdown_d = 2'd3;
            step_d      = '0;
            frame_cnt_d = '0;
            game_rst_d  = 1'b1;
          end
        end
        COUNTDOWN: begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (countdown_q == 2'd1) begin
              scene_d     = PLAY;
              countdown_d = 2'd0;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        PLAY: begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          if (long_hold) begin
            scene_d = TITLE;
          end else if (i_game_over) begin
            scene_d = OVER;
            tmo_d   = '0;
          end else if (pending) begin
            scene_d = PAUSE;
          end
        end
        PAUSE: begin
          if (long_hold) begin
            scene_d = TITLE;
          end else if (pending) begin
            scene_d = PLAY;
          end
        end
        OVER: begin
          if (pending || (tmo_q == TMO_LAST)) begin
            scene_d = TITLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: begin
          scene_d     = TITLE;
          countdown_d = 2'd0;
        end
      endcase
    end
    scene_changed_d = (scene_d != scene_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scene_q         <= TITLE;
      countdown_q     <= 2'd0;
      step_q          <= '0;
      frame_cnt_q     <= '0;
      tmo_q           <= '0;
      scene_changed_q <= 1'b0;
      game_rst_q      <= 1'b0;
    end else begin
      scene_q         <= scene_d;
      countdown_q     <= countdown_d;
      step_q          <= step_d;
      frame_cnt_q     <= frame_cnt_d;
      tmo_q           <= tmo_d;
      scene_changed_q <= scene_changed_d;
      game_rst_q      <= game_rst_d;
    end
  end

  assign o_scene         = scene_q;
  assign o_countdown     = countdown_q;
  assign o_frame_cnt     = frame_cnt_q;
  assign o_scene_changed = scene_changed_q;
  assign o_game_rst      = game_rst_q;

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Scoreboard bench for vga_scene_ctrl: driver queues expected post-frame outputs,
// monitor compares them on the cycle after each frame start.
module tb_vga_scene_ctrl;
  import vga_scene_pkg::*;

  localparam int FPS = 4;
  localparam int OT  = 10;
  localparam int LP  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key = 1'b1;
  logic        fs  = 1'b0;
  logic        go  = 1'b0;
  logic [2:0]  scene;
  logic [1:0]  cd;
  logic [15:0] fc;
  logic        chg;
  logic        grst;

  always #5 clk = ~clk;

  vga_scene_ctrl #(
    .FPS          (FPS),
    .OVER_TIMEOUT (OT),
    .LONG_PRESS   (LP)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_key           (key),
    .i_frame_start   (fs),
    .i_game_over     (go),
    .o_scene         (scene),
    .o_countdown     (cd),
    .o_frame_cnt     (fc),
    .o_scene_changed (chg),
    .o_game_rst      (grst)
  );

  typedef struct {
    int          fr;
    logic [2:0]  sc;
    logic [1:0]  cd;
    logic [15:0] fc;
    logic        chg;
    logic        grst;
  } exp_t;

  exp_t q[$];
  int tests  = 0;
  int fails  = 0;
  int fidx   = 0;
  int mon_fr = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: 19 idle cycles, then a one-cycle frame start.
  task automatic frame(input bit press_on_fs);
    repeat (19) tick();
    fs = 1'b1;
    if (press_on_fs) key = 1'b0;
    tick();
    fs = 1'b0;
    fidx++;
  endtask

  task automatic tap();
    key = 1'b0;
    repeat (3) tick();
    key = 1'b1;
    tick();
  endtask

  task automatic expect_next(input logic [2:0] sc, input logic [1:0] c, input int f,
                             input logic ch, input logic gr);
    exp_t e;
    e.fr   = fidx + 1;
    e.sc   = sc;
    e.cd   = c;
    e.fc   = 16'(f);
    e.chg  = ch;
    e.grst = gr;
    q.push_back(e);
  endtask

  task automatic fx(input logic [2:0] sc, input logic [1:0] c, input int f,
                    input logic ch, input logic gr);
    expect_next(sc, c, f, ch, gr);
    frame(1'b0);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    check({tag, "_scene"}, int'(scene), int'(TITLE));
    check({tag, "_countdown"}, int'(cd), 0);
    check({tag, "_frame_cnt"}, int'(fc), 0);
    check({tag, "_changed"}, int'(chg), 0);
    check({tag, "_game_rst"}, int'(grst), 0);
  endtask

  // Press in TITLE, then the full countdown into PLAY (a stray press mid-count is ignored).
  task automatic do_countdown();
    tap();
    fx(COUNTDOWN, 2'd3, 0, 1'b1, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      if (i == 2) tap();
      fx(COUNTDOWN, 2'(3 - i / 4), 0, 1'b0, 1'b0);
    end
    fx(PLAY, 2'd0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: compare on the cycle after each frame start, then check pulses dropped.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (fs === 1'b1 && rst !== 1'b1) begin
        mon_fr++;
        @(negedge clk);
        while (q.size() > 0 && q[0].fr < mon_fr) begin
          check("missed_expectation_frame", q[0].fr, mon_fr);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].fr == mon_fr) begin
          e = q.pop_front();
          check($sformatf("f%0d_scene", mon_fr), int'(scene), int'(e.sc));
          check($sformatf("f%0d_countdown", mon_fr), int'(cd), int'(e.cd));
          check($sformatf("f%0d_frame_cnt", mon_fr), int'(fc), int'(e.fc));
          check($sformatf("f%0d_changed", mon_fr), int'(chg), int'(e.chg));
          check($sformatf("f%0d_game_rst", mon_fr), int'(grst), int'(e.grst));
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("f%0d_pulses_low", mon_fr), int'({chg, grst}), 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) fx(TITLE, 2'd0, 0, 1'b0, 1'b0);

    do_countdown();
    fx(PLAY, 2'd0, 1, 1'b0, 1'b0);
    fx(PLAY, 2'd0, 2, 1'b0, 1'b0);
    fx(PLAY, 2'd0, 3, 1'b0, 1'b0);

    // Press coinciding with a frame start is applied one frame later.
    expect_next(PLAY, 2'd0, 4, 1'b0, 1'b0);
    frame(1'b1);
    repeat (3) tick();
    key = 1'b1;
    fx(PAUSE, 2'd0, 5, 1'b1, 1'b0);
    fx(PAUSE, 2'd0, 5, 1'b0, 1'b0);
    fx(PAUSE, 2'd0, 5, 1'b0, 1'b0);
    tap();
    fx(PLAY, 2'd0, 5, 1'b1, 1'b0);
    fx(PLAY, 2'd0, 6, 1'b0, 1'b0);

    // Game over outranks a pending press; then timeout back to TITLE.
    tap();
    go = 1'b1;
    fx(OVER, 2'd0, 7, 1'b1, 1'b0);
    go = 1'b0;
    for (int i = 1; i <= 9; i++) fx(OVER, 2'd0, 7, 1'b0, 1'b0);
    fx(TITLE, 2'd0, 7, 1'b1, 1'b0);

    // Long press: pause first, abort at the sixth held frame start.
    do_countdown();
    fx(PLAY, 2'd0, 1, 1'b0, 1'b0);
    key = 1'b0;
    fx(PAUSE, 2'd0, 2, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) fx(PAUSE, 2'd0, 2, 1'b0, 1'b0);
    fx(TITLE, 2'd0, 2, 1'b1, 1'b0);
    fx(TITLE, 2'd0, 2, 1'b0, 1'b0);
    fx(TITLE, 2'd0, 2, 1'b0, 1'b0);
    key = 1'b1;
    tick();

    // Reset mid-countdown while the digit reads 2.
    tap();
    fx(COUNTDOWN, 2'd3, 0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) fx(COUNTDOWN, 2'(3 - i / 4), 0, 1'b0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_idle("mid_reset");
    rst = 1'b0;
    tick();
    fx(TITLE, 2'd0, 0, 1'b0, 1'b0);

    // Hold counter restarts fresh: five held frames pause but do not abort.
    do_countdown();
    fx(PLAY, 2'd0, 1, 1'b0, 1'b0);
    key = 1'b0;
    fx(PAUSE, 2'd0, 2, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) fx(PAUSE, 2'd0, 2, 1'b0, 1'b0);
    key = 1'b1;
    tick();
    tap();
    fx(PLAY, 2'd0, 2, 1'b1, 1'b0);
    fx(PLAY, 2'd0, 3, 1'b0, 1'b0);

    repeat (25) tick();
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scene_ctrl.md
# vga_scene_ctrl

Scene sequencer between the debounced KEY[1] level and the VGA renderer. It turns key presses and game-logic events into a frame-aligned scene state (title, countdown, play, pause, game over). It also keeps a play-time frame counter, so the renderer never switches scenes mid-frame.

## Interface
- FPS, default 60: frame starts per countdown step.
- OVER_TIMEOUT, default 600: frame starts in OVER before automatic return to TITLE.
- LONG_PRESS, default 120: frame starts with the key held that abort PLAY/PAUSE to TITLE.
- i_clk  in  1  system clock, CLOCK_50 domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_key  in  1  debounced key level, active-low (0 = pressed).
- i_frame_start  in  1  one-cycle pulse from VGA at the start of vertical blank.
- i_game_over  in  1  level from game logic, sampled only on i_frame_start.
- o_scene  out  3  current scene_t.
- o_countdown  out  2  countdown digit 3..1 in COUNTDOWN, 0 elsewhere.
- o_frame_cnt  out  16  frames spent in PLAY.
- o_scene_changed  out  1  one-cycle pulse, cycle after any scene change.
- o_game_rst  out  1  one-cycle pulse, cycle after TITLE→COUNTDOWN.

## Operation
- Press event: i_key 1→0 edge against a registered previous value.
  - Sets a single `pending` flag. Further presses while `pending` is set are dropped.
- All scene, counter and countdown updates happen only in a cycle with i_frame_start=1. Outputs reflect the update on the next cycle.
- Press and frame start in the same cycle: the press goes to `pending` and is applied at the following frame start, not this one.
- `pending` is cleared at every frame start, whether or not it was consumed.
- TITLE: pending → COUNTDOWN.
  - Set o_countdown=3, step counter=0, o_frame_cnt=0, pulse o_game_rst.
- COUNTDOWN: each frame start increments the step counter.
  - At FPS-1 the step counter wraps to 0 and o_countdown decrements.
  - If the wrap happens while o_countdown=1: go to PLAY, o_countdown=0.
  - Total duration is exactly 3·FPS frame starts. Presses are ignored.
- PLAY: o_frame_cnt increments each frame start (wraps at 2^16), including the frame start that leaves PLAY. Priority, highest first:
  - hold counter reaches LONG_PRESS → TITLE;
  - i_game_over=1 → OVER;
  - pending → PAUSE.
- PAUSE: o_frame_cnt frozen.
  - Long press → TITLE; otherwise pending → PLAY.
- OVER: timeout counter increments each frame start.
  - pending, or timeout counter = OVER_TIMEOUT-1 → TITLE.
  - Timeout counter clears on entering OVER.
- Hold counter:
  - Counts frame starts with i_key=0 while in PLAY or PAUSE, and saturates at LONG_PRESS.
  - Clears when i_key=1 or in any other scene.
  - Long-press exit clears `pending`.
- A press that starts the hold first causes PLAY→PAUSE. The hold then continues and aborts to TITLE.

## Timing
- Reset values: o_scene=TITLE, o_countdown=0, o_frame_cnt=0, o_scene_changed=0, o_game_rst=0.
- Internal reset values: pending=0, key_prev=1, all internal counters 0.
- Reset mid-countdown or mid-play returns to TITLE on the next cycle with no pulses.
- Latency: frame start at cycle N → new o_scene/o_countdown/o_frame_cnt and pulses valid at N+1. Pulses last exactly one cycle.
- Press latency: one to two frame starts.
- i_frame_start held high for several cycles is treated as one pulse per cycle; the driver guarantees single-cycle pulses.

## Structure
- Package vga_scene_pkg holds:
  - typedef enum logic [2:0] scene_t: TITLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4;
  - localparams for counter widths, sized with $clog2 from the parameters.
- Sub-module scene_key_event: edge detect plus `pending` latch plus hold counter. It outputs pending and long_hold to the FSM.
- The FSM and counters live in vga_scene_ctrl.

## Test plan
Benches use FPS=4, OVER_TIMEOUT=10, LONG_PRESS=6, with a frame start every 20 cycles.
- Reset then idle 5 frames → o_scene=TITLE, o_countdown=0, no pulses.
- Press in TITLE → o_game_rst and o_scene_changed pulse once; o_countdown reads 3,3,3,3,2,…,1. PLAY is reached exactly 12 frame starts after entry.
- In PLAY, press coinciding with frame start N → PAUSE at frame start N+1. Second press → PLAY. o_frame_cnt unchanged during PAUSE.
- In PLAY, i_game_over=1 with pending press → OVER, not PAUSE. After 10 frame starts with no key → TITLE.
- In PLAY, hold key 8 frames → PAUSE after the first frame start, TITLE at the 6th held frame start; hold counter then clears.
- Assert i_rst during COUNTDOWN with o_countdown=2 → next cycle TITLE, o_countdown=0, o_frame_cnt=0.
